// File: rtl/alsu_arbiter.sv
// Round-robin arbiter and op sequencer sharing one ALSU between NUM_REQ requesters,
// with optional grant retention (lock) so shift/rotate chains keep the ALSU to themselves.
module alsu_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned ALSU_LATENCY = 2,
  parameter int unsigned MAX_LOCK     = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [NUM_REQ-1:0]         i_req_lock,
  input  logic [NUM_REQ*17-1:0]      i_req_cmd,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic                       o_rsp_valid,
  input  logic                       i_rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] o_rsp_id,
  output logic signed [5:0]          o_rsp_out,
  output logic                       o_rsp_err,
  output logic                       o_alsu_ce,
  output logic [16:0]                o_alsu_cmd,
  input  logic signed [5:0]          i_alsu_out,
  output logic                       o_busy
);

  localparam int unsigned IdW = $clog2(NUM_REQ);
  localparam int unsigned LcW = $clog2(MAX_LOCK + 1);
  localparam int unsigned WcW = (ALSU_LATENCY > 1) ? $clog2(ALSU_LATENCY) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e            r_state, w_state_next;
  logic [IdW-1:0]    r_ptr, r_owner, r_id;
  logic              r_lock;
  logic [LcW-1:0]    r_lock_cnt;
  logic [16:0]       r_cmd;
  logic [WcW-1:0]    r_wait_cnt;
  logic signed [5:0] r_out;
  logic              r_out_held;

  logic              w_owner_hold, w_gnt_valid, w_accept, w_err;
  logic [IdW-1:0]    w_gnt, w_ptr_next;
  logic [IdW:0]      w_sum;
  logic [16:0]       w_sel_cmd;
  logic [LcW-1:0]    w_cnt_inc;

  // An owner that drops req_valid loses the lock before arbitration in the same cycle.
  always_comb begin
    w_owner_hold = r_lock && i_req_valid[r_owner];
    w_gnt_valid  = 1'b0;
    w_gnt        = '0;
    w_sum        = '0;
    if (w_owner_hold) begin
      w_gnt_valid = 1'b1;
      w_gnt       = r_owner;
    end else begin
      // Descending scan so the smallest offset from the pointer wins.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        w_sum = {1'b0, r_ptr} + (IdW + 1)'(k);
        if (w_sum >= (IdW + 1)'(NUM_REQ)) w_sum = w_sum - (IdW + 1)'(NUM_REQ);
        if (i_req_valid[w_sum[IdW-1:0]]) begin
          w_gnt_valid = 1'b1;
          w_gnt       = w_sum[IdW-1:0];
        end
      end
    end
  end

  always_comb begin
    w_sel_cmd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt == IdW'(i)) w_sel_cmd = i_req_cmd[17*i +: 17];
    end
  end

  assign w_accept   = (r_state == StIdle) && w_gnt_valid && i_rst_n;
  assign w_ptr_next = (w_gnt == IdW'(NUM_REQ - 1)) ? '0 : w_gnt + 1'b1;
  assign w_cnt_inc  = (w_owner_hold ? r_lock_cnt : '0) + LcW'(1);
  assign w_err      = ((r_cmd[5] | r_cmd[4]) & (r_cmd[15] | r_cmd[16])) | (r_cmd[15] & r_cmd[16]);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = StIssue;
      StIssue: w_state_next = (ALSU_LATENCY == 1) ? StResp : StWait;
      StWait:  if (r_wait_cnt == '0) w_state_next = StResp;
      StResp:  if (i_rsp_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr      <= '0;
      r_owner    <= '0;
      r_id       <= '0;
      r_lock     <= 1'b0;
      r_lock_cnt <= '0;
      r_cmd      <= '0;
      r_wait_cnt <= '0;
      r_out      <= '0;
      r_out_held <= 1'b0;
    end else begin
      if (r_state == StIdle) begin
        if (r_lock && !i_req_valid[r_owner]) begin
          r_lock     <= 1'b0;
          r_lock_cnt <= '0;
        end
        if (w_accept) begin
          r_cmd <= {w_sel_cmd[16:1], 1'b0};
          r_id  <= w_gnt;
          r_ptr <= w_ptr_next;
          if (i_req_lock[w_gnt] && (w_cnt_inc != LcW'(MAX_LOCK))) begin
            r_lock     <= 1'b1;
            r_owner    <= w_gnt;
            r_lock_cnt <= w_cnt_inc;
          end else begin
            r_lock     <= 1'b0;
            r_lock_cnt <= '0;
          end
        end
      end
      if (r_state == StIssue) r_wait_cnt <= WcW'(ALSU_LATENCY - 2);
      if ((r_state == StWait) && (r_wait_cnt != '0)) r_wait_cnt <= r_wait_cnt - 1'b1;
      // First RESP cycle passes alsu_out through; later stalled cycles replay the held copy.
      if (r_state == StResp) begin
        if (i_rsp_ready) begin
          r_out_held <= 1'b0;
        end else if (!r_out_held) begin
          r_out      <= i_alsu_out;
          r_out_held <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    o_req_ready = '0;
    if (w_accept) o_req_ready[w_gnt] = 1'b1;
    o_alsu_ce   = (r_state == StIssue) || (r_state == StWait);
    o_alsu_cmd  = o_alsu_ce ? r_cmd : '0;
    o_rsp_valid = (r_state == StResp);
    o_rsp_id    = o_rsp_valid ? r_id : '0;
    o_rsp_out   = o_rsp_valid ? (r_out_held ? r_out : i_alsu_out) : '0;
    o_rsp_err   = o_rsp_valid & w_err;
    o_busy      = (r_state != StIdle);
  end

endmodule

// File: tb/tb_alsu_arbiter.sv
// Bench for alsu_arbiter: behavioural ALSU stub plus a transaction-level arbitration model
// that predicts every output each cycle.
module tb_alsu_arbiter;
  localparam int unsigned N    = 4;
  localparam int unsigned L    = 2;
  localparam int unsigned MAXL = 8;
  localparam int unsigned IW   = 2;
  localparam int unsigned VW   = N + 29 + IW;

  logic              clk, rst_n;
  logic [N-1:0]      v, lk;
  logic [16:0]       cmd [N];
  logic [N*17-1:0]   cmd_flat;
  logic              rr;
  logic [N-1:0]      ready;
  logic              rsp_valid, rsp_err, alsu_ce, busy;
  logic [IW-1:0]     rsp_id;
  logic signed [5:0] rsp_out, alsu_out;
  logic [16:0]       alsu_cmd;

  int nchk, nerr, pol;
  int m_ph, m_ptr, m_own, m_cnt, m_id, e_g;
  bit m_lock;
  logic [16:0]   m_cmd;
  logic [5:0]    m_res;
  logic [VW-1:0] e_vec;

  alsu_arbiter #(.NUM_REQ(N), .ALSU_LATENCY(L), .MAX_LOCK(MAXL)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(v), .i_req_lock(lk), .i_req_cmd(cmd_flat),
    .o_req_ready(ready), .o_rsp_valid(rsp_valid), .i_rsp_ready(rr), .o_rsp_id(rsp_id),
    .o_rsp_out(rsp_out), .o_rsp_err(rsp_err), .o_alsu_ce(alsu_ce), .o_alsu_cmd(alsu_cmd),
    .i_alsu_out(alsu_out), .o_busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    cmd_flat = '0;
    for (int i = 0; i < N; i++) cmd_flat[17*i +: 17] = cmd[i];
  end

  function automatic logic bad(input logic [16:0] c);
    return ((c[5] | c[4]) & (c[15] | c[16])) | (c[15] & c[16]);
  endfunction

  // Behavioural ALSU: invalid ops give 0, shifts/rotates work on the previous result.
  function automatic logic [5:0] alsu_fn(input logic [16:0] c, input logic [5:0] p);
    logic signed [5:0] a, b;
    a = {{3{c[13]}}, c[13:11]};
    b = {{3{c[10]}}, c[10:8]};
    if (bad(c)) return 6'd0;
    case (c[16:14])
      3'd0:    return a & b;
      3'd1:    return a ^ b;
      3'd2:    return a + b + {5'd0, c[7]};
      3'd3:    return a * b;
      3'd4:    return c[1] ? {p[4:0], c[6]} : {c[6], p[5:1]};
      3'd5:    return c[1] ? {p[4:0], p[5]} : {p[0], p[5:1]};
      default: return 6'd0;
    endcase
  endfunction

  function automatic logic [16:0] mk(input int op, input int a, input int b, input bit cin,
                                     input bit sin, input bit ra, input bit dir);
    return {3'(op), 3'(a), 3'(b), cin, sin, ra, 1'b0, 2'b00, dir, 1'b0};
  endfunction

  function automatic logic [16:0] rand_cmd();
    logic [16:0] r;
    r = 17'($urandom);
    r[0] = 1'b0;
    return r;
  endfunction

  // ALSU stub: registered input, result register updated on the second enabled cycle.
  logic [16:0] s_in;
  logic        s_inv;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_in     <= '0;
      s_inv    <= 1'b0;
      alsu_out <= '0;
    end else begin
      s_inv <= alsu_ce;
      if (alsu_ce) begin
        s_in <= alsu_cmd;
        if (s_inv) alsu_out <= alsu_fn(s_in, alsu_out);
      end
    end
  end

  function automatic logic [VW-1:0] obs();
    return {ready, alsu_ce, alsu_cmd, rsp_valid, rsp_id, rsp_out, rsp_err, busy};
  endfunction

  task automatic model_reset();
    m_ph = 0; m_ptr = 0; m_lock = 0; m_cnt = 0; m_own = 0; m_id = 0;
    m_cmd = '0; m_res = '0; e_g = -1;
  endtask

  task automatic model_outputs();
    logic [N-1:0] er;
    logic ce, rv;
    e_g = -1;
    if (m_ph == 0) begin
      if (m_lock && v[m_own]) e_g = m_own;
      else
        for (int k = 0; k < N; k++)
          if (e_g < 0 && v[(m_ptr + k) % N]) e_g = (m_ptr + k) % N;
    end
    er = '0;
    if (e_g >= 0) er[e_g] = 1'b1;
    ce = (m_ph >= 1) && (m_ph <= L);
    rv = (m_ph == L + 1);
    e_vec = {er, ce, ce ? m_cmd : 17'd0, rv, rv ? IW'(m_id) : IW'(0), rv ? m_res : 6'd0,
             rv & bad(m_cmd), m_ph != 0};
  endtask

  task automatic model_advance();
    if (m_ph == 0) begin
      if (m_lock && !v[m_own]) begin m_lock = 0; m_cnt = 0; end
      if (e_g >= 0) begin
        m_cmd = {cmd[e_g][16:1], 1'b0};
        m_id  = e_g;
        m_ptr = (e_g + 1) % N;
        m_ph  = 1;
        if (lk[e_g]) begin
          m_cnt++;
          if (m_cnt >= MAXL) begin m_lock = 0; m_cnt = 0; end
          else begin m_lock = 1; m_own = e_g; end
        end else begin
          m_lock = 0; m_cnt = 0;
        end
      end
    end else if (m_ph <= L) begin
      if (m_ph == L) m_res = alsu_fn(m_cmd, m_res);
      m_ph++;
    end else if (rr) begin
      m_ph = 0;
    end
  endtask

  // Requester behaviour after each edge: 0 one-shot, 1 hold forever, 2 random.
  task automatic policy();
    for (int i = 0; i < N; i++) begin
      if (pol == 2) begin
        if (i == e_g || !v[i]) begin
          if ($urandom_range(0, 2) != 0) begin
            v[i] = 1'b1; cmd[i] = rand_cmd(); lk[i] = 1'($urandom_range(0, 1));
          end else v[i] = 1'b0;
        end
      end else if (pol == 0 && i == e_g) v[i] = 1'b0;
    end
    if (pol == 2) rr = ($urandom_range(0, 3) != 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_advance();
    #1;
    policy();
  endtask

  task automatic reset_pulse();
    v = '0; lk = '0; rr = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    v = '1; lk = '0; rr = 1'b1; pol = 0;
    for (int i = 0; i < N; i++) cmd[i] = rand_cmd();
    @(negedge clk);
    nchk++;
    if (obs() !== '0) begin nerr++; $display("FAIL reset_state got %h need 0", obs()); end
    @(posedge clk); #1;
    rst_n = 1'b1; model_reset(); v = 4'b0100;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); model_outputs();
      nchk++;
      if (obs() !== e_vec) begin nerr++; $display("FAIL pre_reset got %h need %h", obs(), e_vec); end
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    nchk++;
    if (obs() !== '0) begin nerr++; $display("FAIL reset_async got %h need 0", obs()); end
    model_reset(); v = 4'b1010;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); model_outputs();
      nchk++;
      if (obs() !== e_vec) begin nerr++; $display("FAIL post_reset got %h need %h", obs(), e_vec); end
      if (c == 0) begin
        nchk++;
        if (ready !== 4'b0010) begin nerr++; $display("FAIL first_grant got %b need 0010", ready); end
      end
      step();
    end
  endtask

  task automatic test_add();
    reset_pulse(); pol = 0;
    cmd[0] = mk(2, 3, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    v = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); model_outputs();
      nchk++;
      if (obs() !== e_vec) begin nerr++; $display("FAIL add_cyc%0d got %h need %h", c, obs(), e_vec); end
      if (c == 3) begin
        nchk++;
        if ({rsp_valid, rsp_out, rsp_id, rsp_err} !== {1'b1, 6'sd6, 2'd0, 1'b0}) begin
          nerr++;
          $display("FAIL add_rsp got v%b out%0d id%0d err%b need v1 out6 id0 err0",
                   rsp_valid, rsp_out, rsp_id, rsp_err);
        end
      end
      step();
    end
  endtask

  task automatic test_round_robin();
    int gq[$];
    int exp_rr[6] = '{0, 1, 2, 3, 0, 1};
    reset_pulse(); pol = 1;
    for (int i = 0; i < N; i++) cmd[i] = mk(1, $urandom_range(0, 7), $urandom_range(0, 7), 0, 0, 0, 0);
    v = '1;
    for (int c = 0; c < 40 && gq.size() < 6; c++) begin
      @(negedge clk); model_outputs();
      nchk++;
      if (obs() !== e_vec) begin nerr++; $display("FAIL rr_cyc got %h need %h", obs(), e_vec); end
      for (int i = 0; i < N; i++) if (ready[i]) gq.push_back(i);
      step();
    end
    for (int k = 0; k < 6; k++) begin
      nchk++;
      if (k >= gq.size()) begin nerr++; $display("FAIL rr_order%0d got none need %0d", k, exp_rr[k]); end
      else if (gq[k] != exp_rr[k]) begin
        nerr++; $display("FAIL rr_order%0d got %0d need %0d", k, gq[k], exp_rr[k]);
      end
    end
  endtask

  task automatic test_lock_chain();
    int gq[$];
    logic [5:0] oq[$];
    logic [5:0] want;
    reset_pulse(); pol = 1;
    cmd[1] = mk(4, $urandom_range(0, 7), $urandom_range(0, 7), 0, 1, 0, 1);
    cmd[2] = mk(0, 5, 3, 0, 0, 0, 0);
    lk = 4'b0010; v = 4'b0110;
    for (int c = 0; c < 80 && gq.size() < 9; c++) begin
      @(negedge clk); model_outputs();
      nchk++;
      if (obs() !== e_vec) begin nerr++; $display("FAIL lock_cyc got %h need %h", obs(), e_vec); end
      for (int i = 0; i < N; i++) if (ready[i]) gq.push_back(i);
      if (rsp_valid && rsp_id == 2'd1) oq.push_back(rsp_out);
      step();
    end
    for (int k = 0; k < 9; k++) begin
      nchk++;
      if (k >= gq.size() || gq[k] != ((k < 8) ? 1 : 2)) begin
        nerr++; $display("FAIL lock_grant%0d got %0d need %0d", k, (k < gq.size()) ? gq[k] : -1,
                         (k < 8) ? 1 : 2);
      end
    end
    for (int k = 0; k < 8; k++) begin
      want = 6'((64'd1 << (k + 1)) - 1);
      nchk++;
      if (k >= oq.size() || oq[k] !== want) begin
        nerr++; $display("FAIL shift_chain%0d got %h need %h", k, (k < oq.size()) ? oq[k] : 6'hx, want);
      end
    end
  endtask

  task automatic test_invalid();
    reset_pulse(); pol = 0;
    for (int t = 0; t < 2; t++) begin
      cmd[0] = (t == 0) ? mk(6, $urandom_range(1, 7), $urandom_range(1, 7), 0, 0, 0, 0)
                        : mk(2, 3, 2, 1, 0, 1, 0);
      v = 4'b0001;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk); model_outputs();
        nchk++;
        if (obs() !== e_vec) begin nerr++; $display("FAIL inv%0d_cyc got %h need %h", t, obs(), e_vec); end
        if (c == 3) begin
          nchk++;
          if ({rsp_valid, rsp_err, rsp_out} !== {1'b1, 1'b1, 6'd0}) begin
            nerr++; $display("FAIL inv%0d_rsp got v%b err%b out%0d need v1 err1 out0",
                             t, rsp_valid, rsp_err, rsp_out);
          end
        end
        step();
      end
    end
  endtask

  task automatic test_backpressure();
    int stall, post;
    bit done;
    logic [8:0] snap;
    reset_pulse(); pol = 1;
    cmd[0] = mk(3, 3, 5, 0, 0, 0, 0);
    cmd[1] = mk(2, 1, 1, 1, 0, 0, 0);
    v = 4'b0011; rr = 1'b0;
    stall = 0; post = -1; done = 0; snap = '0;
    for (int c = 0; c < 30 && !done; c++) begin
      @(negedge clk); model_outputs();
      nchk++;
      if (obs() !== e_vec) begin nerr++; $display("FAIL bp_cyc got %h need %h", obs(), e_vec); end
      if (post >= 0) begin
        nchk++;
        if (ready !== 4'b0010) begin nerr++; $display("FAIL bp_next_grant got %b need 0010", ready); end
        done = 1;
      end else if (rsp_valid) begin
        if (stall == 0) snap = {rsp_id, rsp_out, rsp_err};
        else begin
          nchk++;
          if ({rsp_id, rsp_out, rsp_err} !== snap) begin
            nerr++; $display("FAIL bp_stable got %h need %h", {rsp_id, rsp_out, rsp_err}, snap);
          end
        end
        if (rr) post = 0;
        stall++;
      end
      step();
      if (stall >= 5) rr = 1'b1;
    end
    if (!done) begin nchk++; nerr++; $display("FAIL bp_timeout got no grant need grant"); end
  endtask

  task automatic test_random();
    reset_pulse(); pol = 2;
    for (int i = 0; i < N; i++) begin
      v[i] = 1'($urandom_range(0, 1)); cmd[i] = rand_cmd(); lk[i] = 1'($urandom_range(0, 1));
    end
    for (int c = 0; c < 600; c++) begin
      @(negedge clk); model_outputs();
      nchk++;
      if (obs() !== e_vec) begin nerr++; $display("FAIL rand_cyc%0d got %h need %h", c, obs(), e_vec); end
      step();
    end
  endtask

  initial begin
    nchk = 0; nerr = 0; pol = 0; rst_n = 1'b0; rr = 1'b1; v = '0; lk = '0;
    for (int i = 0; i < N; i++) cmd[i] = '0;
    model_reset();
    test_reset();
    test_add();
    test_round_robin();
    test_lock_chain();
    test_invalid();
    test_backpressure();
    test_random();
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
